// File: rtl/control_pkg.sv
// Shared types for the bytecode control FSM: state enum, opcode constants,
// decode entry struct. Optional feature macro: CONTROL_ILLEGAL_TRAP_EN.
package control_pkg;

  typedef enum logic [1:0] {
    S_DECODE,
    S_EXEC,
    S_DONE
`ifdef CONTROL_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_ICONST_M1 = 8'h02;
  localparam logic [7:0] OP_ICONST_5  = 8'h08;
  localparam logic [7:0] OP_BIPUSH    = 8'h10;
  localparam logic [7:0] OP_SIPUSH    = 8'h11;
  localparam logic [7:0] OP_ILOAD     = 8'h15;
  localparam logic [7:0] OP_ILOAD_0   = 8'h1A;
  localparam logic [7:0] OP_ILOAD_3   = 8'h1D;
  localparam logic [7:0] OP_ISTORE    = 8'h36;
  localparam logic [7:0] OP_ISTORE_0  = 8'h3B;
  localparam logic [7:0] OP_ISTORE_3  = 8'h3E;
  localparam logic [7:0] OP_POP       = 8'h57;
  localparam logic [7:0] OP_DUP       = 8'h59;
  localparam logic [7:0] OP_IADD      = 8'h60;
  localparam logic [7:0] OP_ISUB      = 8'h64;
  localparam logic [7:0] OP_IMUL      = 8'h68;
  localparam logic [7:0] OP_IAND      = 8'h7E;
  localparam logic [7:0] OP_IOR       = 8'h80;
  localparam logic [7:0] OP_IXOR      = 8'h82;
  localparam logic [7:0] OP_IINC      = 8'h84;
  localparam logic [7:0] OP_IF_FIRST  = 8'h99;
  localparam logic [7:0] OP_IF_LAST   = 8'hA6;
  localparam logic [7:0] OP_GOTO      = 8'hA7;
  localparam logic [7:0] OP_RETURN    = 8'hB1;

  typedef struct packed {
    logic [1:0] argcount;
    logic [3:0] cycles;
    logic       legal;
  } dec_t;

  function automatic dec_t mk_entry(input logic [1:0] argc, input logic [3:0] cyc);
    return '{argcount: argc, cycles: cyc, legal: 1'b1};
  endfunction

endpackage

// File: rtl/control_if.sv
// Bytecode/status bundle between the control FSM (slave) and the fetch/datapath side (master).
// Optional feature macro: CONTROL_ILLEGAL_TRAP_EN adds illegal_op.
interface control_if;
  logic [7:0] op_code;
  logic [1:0] argcount;
  logic       op_done;
  logic [7:0] cur_op;   // opcode captured at the last DECODE edge
`ifdef CONTROL_ILLEGAL_TRAP_EN
  logic       illegal_op;

  modport master (output op_code, input argcount, op_done, cur_op, illegal_op);
  modport slave  (input op_code, output argcount, op_done, cur_op, illegal_op);
`else
  modport master (output op_code, input argcount, op_done, cur_op);
  modport slave  (input op_code, output argcount, op_done, cur_op);
`endif
endinterface

// File: rtl/control_op_decode.sv
// Combinational bytecode decoder: opcode -> {argcount, execute cycles, legal}.
import control_pkg::*;

module op_decode #(
  parameter int IMUL_CYCLES = 4
) (
  input  logic [7:0] op_code,
  output dec_t       entry
);
  always_comb begin
    entry = '{argcount: 2'd0, cycles: 4'd1, legal: 1'b0};
    case (op_code) inside
      OP_NOP, [OP_ICONST_M1:OP_ICONST_5]:          entry = mk_entry(2'd0, 4'd1);
      OP_BIPUSH:                                   entry = mk_entry(2'd1, 4'd1);
      OP_SIPUSH, OP_GOTO:                          entry = mk_entry(2'd2, 4'd1);
      OP_ILOAD, OP_ISTORE:                         entry = mk_entry(2'd1, 4'd2);
      [OP_ILOAD_0:OP_ILOAD_3], [OP_ISTORE_0:OP_ISTORE_3]:
                                                   entry = mk_entry(2'd0, 4'd2);
      OP_POP, OP_DUP, OP_IADD, OP_ISUB, OP_IAND, OP_IOR, OP_IXOR, OP_RETURN:
                                                   entry = mk_entry(2'd0, 4'd1);
      OP_IMUL:                                     entry = mk_entry(2'd0, 4'(IMUL_CYCLES));
      OP_IINC:                                     entry = mk_entry(2'd2, 4'd3);
      [OP_IF_FIRST:OP_IF_LAST]:                    entry = mk_entry(2'd2, 4'd2);
      default: ;
    endcase
  end
endmodule

// File: rtl/control.sv
// Bytecode sequencing FSM: DECODE -> EXEC (N cycles) -> DONE, all outputs registered.
// Optional feature macro: CONTROL_ILLEGAL_TRAP_EN (illegal opcode traps into HALT).
import control_pkg::*;

module control #(
  parameter int IMUL_CYCLES = 4
) (
  input  logic      clk,
  input  logic      rst,
  control_if.slave  bus
);
  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] arg_r, arg_n;
  logic [7:0] op_r, op_n;
  logic       done_r, done_n;
  logic       ill_r, ill_n;
  dec_t       dec;

  op_decode #(.IMUL_CYCLES(IMUL_CYCLES)) u_dec (.op_code(bus.op_code), .entry(dec));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_DECODE;
      cnt    <= '0;
      arg_r  <= '0;
      op_r   <= '0;
      done_r <= 1'b0;
      ill_r  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      arg_r  <= arg_n;
      op_r   <= op_n;
      done_r <= done_n;
      ill_r  <= ill_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    arg_n   = arg_r;
    op_n    = op_r;
    done_n  = 1'b0;
    ill_n   = ill_r;
    case (state)
      S_DECODE: begin
        // illegal codes behave as a one-cycle, zero-operand nop
        op_n    = bus.op_code;
        arg_n   = dec.legal ? dec.argcount : 2'd0;
        cnt_n   = dec.legal ? dec.cycles - 4'd1 : 4'd0;
        state_n = S_EXEC;
`ifdef CONTROL_ILLEGAL_TRAP_EN
        if (!dec.legal) begin
          ill_n   = 1'b1;
          state_n = S_HALT;
        end
`endif
      end
      S_EXEC: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          done_n  = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: state_n = S_DECODE;
`ifdef CONTROL_ILLEGAL_TRAP_EN
      S_HALT: state_n = S_HALT;
`endif
      default: state_n = S_DECODE;
    endcase
  end

  assign bus.argcount = arg_r;
  assign bus.op_done  = done_r;
  assign bus.cur_op   = op_r;
`ifdef CONTROL_ILLEGAL_TRAP_EN
  assign bus.illegal_op = ill_r;
`else
  logic unused_ill;
  assign unused_ill = ill_r;
`endif
endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: decode-table vectors, hand-written corner
// sequences and a randomized run against a cycle-count reference model.
module tb_control;
  localparam int IMUL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  control_if bus();

  control #(.IMUL_CYCLES(IMUL)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [7:0] op; logic [1:0] arg; int n; } vec_t;
  typedef struct { logic [1:0] arg; int n; bit legal; } ref_t;

  vec_t vecs[$];

  // Reference model: counts edges since capture instead of tracking FSM states.
  bit         m_busy, m_halt, m_done, m_ill;
  int         m_k, m_n;
  logic [1:0] m_arg;
  logic [7:0] m_op;

  function automatic ref_t ref_decode(input logic [7:0] op);
    ref_t r;
    r = '{arg: 2'd0, n: 1, legal: 1'b1};
    if (op == 8'h00 || (op >= 8'h02 && op <= 8'h08)) r = '{2'd0, 1, 1'b1};
    else if (op == 8'h10)                             r = '{2'd1, 1, 1'b1};
    else if (op == 8'h11 || op == 8'hA7)              r = '{2'd2, 1, 1'b1};
    else if (op == 8'h15 || op == 8'h36)              r = '{2'd1, 2, 1'b1};
    else if ((op >= 8'h1A && op <= 8'h1D) || (op >= 8'h3B && op <= 8'h3E))
                                                      r = '{2'd0, 2, 1'b1};
    else if (op == 8'h57 || op == 8'h59 || op == 8'h60 || op == 8'h64 ||
             op == 8'h7E || op == 8'h80 || op == 8'h82 || op == 8'hB1)
                                                      r = '{2'd0, 1, 1'b1};
    else if (op == 8'h68)                             r = '{2'd0, IMUL, 1'b1};
    else if (op == 8'h84)                             r = '{2'd2, 3, 1'b1};
    else if (op >= 8'h99 && op <= 8'hA6)              r = '{2'd2, 2, 1'b1};
    else                                              r = '{2'd0, 1, 1'b0};
    return r;
  endfunction

  task automatic model_edge();
    ref_t r;
    if (rst) begin
      m_busy = 0; m_halt = 0; m_done = 0; m_ill = 0; m_k = 0; m_n = 1;
      m_arg = '0; m_op = '0;
    end else if (m_halt) begin
      m_done = 0;
    end else if (!m_busy) begin
      r = ref_decode(bus.op_code);
      m_op = bus.op_code; m_arg = r.arg; m_n = r.n; m_done = 0;
`ifdef CONTROL_ILLEGAL_TRAP_EN
      if (!r.legal) begin m_halt = 1; m_ill = 1; end
      else begin m_busy = 1; m_k = 0; end
`else
      m_busy = 1; m_k = 0;
`endif
    end else begin
      m_k++;
      m_done = (m_k == m_n);
      if (m_k == m_n + 1) m_busy = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_model(input string nm);
    check({nm, ".op_done"},  bus.op_done,  m_done);
    check({nm, ".argcount"}, bus.argcount, m_arg);
    check({nm, ".cur_op"},   bus.cur_op,   m_op);
`ifdef CONTROL_ILLEGAL_TRAP_EN
    check({nm, ".illegal"},  bus.illegal_op, m_ill);
`endif
  endtask

  // Capture op at the next edge, then measure edges until op_done with junk on op_code.
  task automatic run_op(input string nm, input logic [7:0] op, input logic [1:0] ea, input int en);
    int lat;
    bit seen;
    bus.op_code = op;
    tick();
    check({nm, " arg@capture"}, bus.argcount, ea);
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      bus.op_code = 8'($urandom);
      tick();
      lat++;
      seen = bus.op_done;
      check_model({nm, " exec"});
    end
    check({nm, " latency"}, lat, en);
    check({nm, " arg@done"}, bus.argcount, ea);
    tick();
    check({nm, " pulse_width"}, bus.op_done, 0);
    check({nm, " arg_hold"}, bus.argcount, ea);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] op;
    vecs.push_back('{8'h00, 2'd0, 1});    vecs.push_back('{8'h02, 2'd0, 1});
    vecs.push_back('{8'h08, 2'd0, 1});    vecs.push_back('{8'h10, 2'd1, 1});
    vecs.push_back('{8'h11, 2'd2, 1});    vecs.push_back('{8'h15, 2'd1, 2});
    vecs.push_back('{8'h1A, 2'd0, 2});    vecs.push_back('{8'h1D, 2'd0, 2});
    vecs.push_back('{8'h36, 2'd1, 2});    vecs.push_back('{8'h3B, 2'd0, 2});
    vecs.push_back('{8'h3E, 2'd0, 2});    vecs.push_back('{8'h57, 2'd0, 1});
    vecs.push_back('{8'h59, 2'd0, 1});    vecs.push_back('{8'h60, 2'd0, 1});
    vecs.push_back('{8'h64, 2'd0, 1});    vecs.push_back('{8'h68, 2'd0, IMUL});
    vecs.push_back('{8'h7E, 2'd0, 1});    vecs.push_back('{8'h80, 2'd0, 1});
    vecs.push_back('{8'h82, 2'd0, 1});    vecs.push_back('{8'h84, 2'd2, 3});
    vecs.push_back('{8'h99, 2'd2, 2});    vecs.push_back('{8'hA6, 2'd2, 2});
    vecs.push_back('{8'hA7, 2'd2, 1});    vecs.push_back('{8'hB1, 2'd0, 1});

    // reset state
    bus.op_code = 8'h5A;
    rst = 1'b1;
    tick(); tick();
    check("reset op_done",  bus.op_done,  0);
    check("reset argcount", bus.argcount, 0);
    check("reset cur_op",   bus.cur_op,   0);
`ifdef CONTROL_ILLEGAL_TRAP_EN
    check("reset illegal",  bus.illegal_op, 0);
`endif
    rst = 1'b0;

    // decode table, back to back: each capture lands one cycle after DONE
    foreach (vecs[i]) run_op($sformatf("vec[%0d]=%02h", i, vecs[i].op), vecs[i].op, vecs[i].arg, vecs[i].n);

    // iinc aborted by reset in its second EXEC cycle
    bus.op_code = 8'h84;
    tick();
    tick();
    check("iinc exec2 no done", bus.op_done, 0);
    rst = 1'b1;
    tick();
    check("iinc rst op_done",  bus.op_done,  0);
    check("iinc rst argcount", bus.argcount, 0);
    rst = 1'b0;
    bus.op_code = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_model("post-abort");
    end
    check("post-abort nop done", bus.op_done, 0);
    rst = 1'b1; tick(); rst = 1'b0;

    // if*: op_code toggled throughout EXEC must not disturb argcount
    bus.op_code = 8'h99;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.op_code = (i % 2 == 0) ? 8'h00 : 8'h10;
      tick();
      check($sformatf("if toggle arg[%0d]", i), bus.argcount, 2);
    end
    check("if toggle cur_op", bus.cur_op, 8'h99);

    // illegal opcode
`ifdef CONTROL_ILLEGAL_TRAP_EN
    bus.op_code = 8'hFF;
    tick();
    check("illegal flag", bus.illegal_op, 1);
    for (int i = 0; i < 10; i++) begin
      bus.op_code = 8'h00;
      tick();
      check($sformatf("halt no done[%0d]", i), bus.op_done, 0);
    end
    check("halt sticky", bus.illegal_op, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("illegal cleared", bus.illegal_op, 0);
`else
    run_op("illegal FF", 8'hFF, 2'd0, 1);
    run_op("illegal 01", 8'h01, 2'd0, 1);
`endif

    // randomized run against the reference model
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) op = 8'($urandom);
      else op = vecs[$urandom_range(0, vecs.size() - 1)].op;
      bus.op_code = op;
      tick();
      check_model($sformatf("rand[%0d]", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
